// File: rtl/chunk_scheduler.sv
// chunk_scheduler
//   Splits a frame of img_pixels pixels into chunks of up to CHUNK_PIX pixels
//   and sequences the pixel controller and edge-filter stage. The stages are
//   pipelined: operation k reads chunk k and writes back chunk k-1. A final
//   flush operation reads nothing and writes the last chunk.
//
//   Optional build macro: CHUNK_TIMEOUT_EN enables a watchdog.
//   With it, a wait that lasts TIMEOUT_CYCLES cycles enters a sticky error
//   state that only n_rst can clear.
//
// Ports
//   clk, n_rst          clock, asynchronous active-low reset
//   start               begin frame (pulse, ignored while busy)
//   img_pixels          total pixels in frame
//   src_base, dst_base  first source / destination SRAM address
//   pc_start            one-cycle request to the pixel controller
//   pc_rd_offset        read start address      (held until pc_done)
//   pc_wr_offset        write start address     (held until pc_done)
//   pc_num_rd           pixels to read          (held until pc_done)
//   pc_num_wr           pixels to write         (held until pc_done)
//   pc_done             pixel controller finished the operation (pulse)
//   proc_start          one-cycle start to the edge-filter stage
//   proc_done           edge filter finished the chunk (pulse)
//   chunk_idx           index of the current read chunk
//   busy                frame in progress
//   done                one-cycle frame-complete pulse
//   error               watchdog fault, sticky
module chunk_scheduler #(
    parameter int ADDR_BITS      = 16,
    parameter int CHUNK_PIX      = 20,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic [24:0]          img_pixels,
    input  logic [ADDR_BITS-1:0] src_base,
    input  logic [ADDR_BITS-1:0] dst_base,
    output logic                 pc_start,
    output logic [ADDR_BITS-1:0] pc_rd_offset,
    output logic [ADDR_BITS-1:0] pc_wr_offset,
    output logic [24:0]          pc_num_rd,
    output logic [24:0]          pc_num_wr,
    input  logic                 pc_done,
    output logic                 proc_start,
    input  logic                 proc_done,
    output logic [15:0]          chunk_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_PC, PROC, WAIT_PROC, FIN, ERR
    } state_t;

    localparam logic [24:0]          CHUNK_N    = 25'(CHUNK_PIX);
    localparam logic [ADDR_BITS-1:0] CHUNK_STEP = ADDR_BITS'(CHUNK_PIX);

    state_t                 state_q, state_d;
    logic [24:0]            remaining_q, remaining_d;
    logic [24:0]            prev_cnt_q, prev_cnt_d;
    logic [15:0]            chunk_idx_q, chunk_idx_d;
    logic [ADDR_BITS-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
    logic                   pc_start_q, pc_start_d;
    logic [ADDR_BITS-1:0]   pc_rd_offset_q, pc_rd_offset_d;
    logic [ADDR_BITS-1:0]   pc_wr_offset_q, pc_wr_offset_d;
    logic [24:0]            pc_num_rd_q, pc_num_rd_d;
    logic [24:0]            pc_num_wr_q, pc_num_wr_d;
    logic                   proc_start_q, proc_start_d;
    logic                   done_q, done_d;
    logic                   timeout;

`ifdef CHUNK_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               error_q, error_d;

    always_comb begin
        timer_d = '0;
        if (state_q == WAIT_PC || state_q == WAIT_PROC) begin
            timer_d = timer_q + TIMER_W'(1);
        end
    end

    assign timeout = (state_q == WAIT_PC || state_q == WAIT_PROC) &&
                     (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));
    assign error_d = error_q | (state_d == ERR);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            timer_q <= '0;
            error_q <= 1'b0;
        end else begin
            timer_q <= timer_d;
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    // Watchdog compiled out: the comparison below is constant false.
    assign timeout = (TIMEOUT_CYCLES < 0);
    assign error   = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= IDLE;
            remaining_q    <= '0;
            prev_cnt_q     <= '0;
            chunk_idx_q    <= '0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            pc_start_q     <= 1'b0;
            pc_rd_offset_q <= '0;
            pc_wr_offset_q <= '0;
            pc_num_rd_q    <= '0;
            pc_num_wr_q    <= '0;
            proc_start_q   <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            remaining_q    <= remaining_d;
            prev_cnt_q     <= prev_cnt_d;
            chunk_idx_q    <= chunk_idx_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            pc_start_q     <= pc_start_d;
            pc_rd_offset_q <= pc_rd_offset_d;
            pc_wr_offset_q <= pc_wr_offset_d;
            pc_num_rd_q    <= pc_num_rd_d;
            pc_num_wr_q    <= pc_num_wr_d;
            proc_start_q   <= proc_start_d;
            done_q         <= done_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        remaining_d    = remaining_q;
        prev_cnt_d     = prev_cnt_q;
        chunk_idx_d    = chunk_idx_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        pc_start_d     = 1'b0;
        pc_rd_offset_d = pc_rd_offset_q;
        pc_wr_offset_d = pc_wr_offset_q;
        pc_num_rd_d    = pc_num_rd_q;
        pc_num_wr_d    = pc_num_wr_q;
        proc_start_d   = 1'b0;
        done_d         = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    remaining_d = img_pixels;
                    prev_cnt_d  = '0;
                    chunk_idx_d = '0;
                    rd_ptr_d    = src_base;
                    wr_ptr_d    = dst_base;
                    state_d     = (img_pixels == '0) ? FIN : ISSUE;
                end
            end
            ISSUE: begin
                pc_num_rd_d    = (remaining_q > CHUNK_N) ? CHUNK_N : remaining_q;
                pc_num_wr_d    = prev_cnt_q;
                pc_rd_offset_d = rd_ptr_q;
                pc_wr_offset_d = wr_ptr_q;
                pc_start_d     = 1'b1;
                state_d        = WAIT_PC;
            end
            WAIT_PC: begin
                if (pc_done) begin
                    state_d = (pc_num_rd_q != '0) ? PROC : FIN;
                end else if (timeout) begin
                    state_d = ERR;
                end
            end
            PROC: begin
                proc_start_d = 1'b1;
                state_d      = WAIT_PROC;
            end
            WAIT_PROC: begin
                if (proc_done) begin
                    prev_cnt_d  = pc_num_rd_q;
                    remaining_d = remaining_q - pc_num_rd_q;
                    chunk_idx_d = chunk_idx_q + 16'd1;
                    // Running pointers replace base+idx*CHUNK_PIX; the write
                    // pointer lags one chunk, so it stays put after chunk 0.
                    rd_ptr_d    = rd_ptr_q + CHUNK_STEP;
                    if (chunk_idx_q != '0) begin
                        wr_ptr_d = wr_ptr_q + CHUNK_STEP;
                    end
                    state_d     = ISSUE;
                end else if (timeout) begin
                    state_d = ERR;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pc_start     = pc_start_q;
    assign pc_rd_offset = pc_rd_offset_q;
    assign pc_wr_offset = pc_wr_offset_q;
    assign pc_num_rd    = pc_num_rd_q;
    assign pc_num_wr    = pc_num_wr_q;
    assign proc_start   = proc_start_q;
    assign chunk_idx    = chunk_idx_q;
    assign busy         = (state_q != IDLE) && (state_q != ERR);
    assign done         = done_q;

endmodule
